// File: rtl/raster_sweep_writer_pkg.sv
// Shared types for the raster sweep writer: screen-space triangle, FSM state,
// bounding box and small min/max helpers.
package raster_sweep_writer_pkg;

  localparam int unsigned RSW_COORD_BITS = 16;

  typedef struct packed {
    logic signed [RSW_COORD_BITS-1:0] x;
    logic signed [RSW_COORD_BITS-1:0] y;
  } vertex_2d;

  typedef vertex_2d [2:0] tri_2d;

  typedef enum logic [2:0] {StIdle, StSetup, StSweep, StDrain, StClear} rsw_state_e;

  typedef struct packed {
    logic signed [RSW_COORD_BITS-1:0] xmin;
    logic signed [RSW_COORD_BITS-1:0] xmax;
    logic signed [RSW_COORD_BITS-1:0] ymin;
    logic signed [RSW_COORD_BITS-1:0] ymax;
  } bbox_t;

  function automatic logic signed [RSW_COORD_BITS-1:0] min3(
    input logic signed [RSW_COORD_BITS-1:0] a,
    input logic signed [RSW_COORD_BITS-1:0] b,
    input logic signed [RSW_COORD_BITS-1:0] c
  );
    logic signed [RSW_COORD_BITS-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [RSW_COORD_BITS-1:0] max3(
    input logic signed [RSW_COORD_BITS-1:0] a,
    input logic signed [RSW_COORD_BITS-1:0] b,
    input logic signed [RSW_COORD_BITS-1:0] c
  );
    logic signed [RSW_COORD_BITS-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/rsw_addr_pipe.sv
// Fixed-latency delay line for {valid, addr}; keeps each pixel address aligned
// with the coverage answer returned DEPTH cycles after the coordinate was issued.
module rsw_addr_pipe #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_addr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_addr,
  output logic             any_valid
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] addr_q [DEPTH];

  // Shift register; reset clears valids and addresses so pix_addr idles at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/raster_sweep_writer.sv
// Per-triangle raster sweep engine: scans a triangle's pixel region, asks an
// external coverage unit about each coordinate and writes colour only where
// covered. Also clears the whole frame on request.
// Build option: define RAST_BBOX_EN to limit the sweep to the clamped vertex
// bounding box; otherwise every triangle sweeps the full frame.
module raster_sweep_writer
  import raster_sweep_writer_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = 512,
  parameter int unsigned FRAME_HEIGHT = 384,
  parameter int unsigned COORD_BITS   = RSW_COORD_BITS,  // must equal RSW_COORD_BITS
  parameter int unsigned ADDR_BITS    = 18,
  parameter int unsigned COLOR_WIDTH  = 16,
  parameter int unsigned FILL_LATENCY = 3,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tri_valid,
  output logic                   tri_ready,
  input  tri_2d                  tri_in,
  input  logic [COLOR_WIDTH-1:0] tri_color,
  input  logic                   clear_req,
  output logic                   busy,
  output logic                   tri_done,
  output logic [COORD_BITS-1:0]  fill_hcount,
  output logic [COORD_BITS-1:0]  fill_vcount,
  output tri_2d                  fill_triangle,
  input  logic                   fill_is_within,
  output logic                   pix_we,
  output logic [ADDR_BITS-1:0]   pix_addr,
  output logic [COLOR_WIDTH-1:0] pix_data
);

  localparam logic signed [COORD_BITS-1:0] XLIM  = COORD_BITS'(FRAME_WIDTH - 1);
  localparam logic signed [COORD_BITS-1:0] YLIM  = COORD_BITS'(FRAME_HEIGHT - 1);
  localparam logic signed [COORD_BITS-1:0] CONE  = COORD_BITS'(1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_WIDTH * FRAME_HEIGHT - 1);

  rsw_state_e                    state_q;
  tri_2d                         tri_q;
  logic [COLOR_WIDTH-1:0]        color_q;
  logic signed [COORD_BITS-1:0]  x_q, y_q, xmin_q, xmax_q, ymax_q;
  logic                          issue_valid_q;
  logic [ADDR_BITS-1:0]          issue_addr_q;
  logic                          clr_we_q;
  logic [ADDR_BITS-1:0]          clr_addr_q;
  logic                          clear_pend_q;
  logic                          tri_done_q;

  bbox_t                         bbox_c;
  logic                          bbox_empty;
  logic                          pipe_valid, pipe_any;
  logic [ADDR_BITS-1:0]          pipe_addr;

  function automatic logic [ADDR_BITS-1:0] addr_of(input logic signed [COORD_BITS-1:0] x,
                                                   input logic signed [COORD_BITS-1:0] y);
    return ADDR_BITS'($unsigned(y)) * ADDR_BITS'(FRAME_WIDTH) + ADDR_BITS'($unsigned(x));
  endfunction

`ifdef RAST_BBOX_EN
  logic signed [COORD_BITS-1:0] xmin_raw, xmax_raw, ymin_raw, ymax_raw;
  localparam logic signed [COORD_BITS-1:0] CZERO = '0;

  // Vertex bounding box, clamped to the frame; empty when wholly off-screen.
  always_comb begin
    xmin_raw = min3(tri_q[0].x, tri_q[1].x, tri_q[2].x);
    xmax_raw = max3(tri_q[0].x, tri_q[1].x, tri_q[2].x);
    ymin_raw = min3(tri_q[0].y, tri_q[1].y, tri_q[2].y);
    ymax_raw = max3(tri_q[0].y, tri_q[1].y, tri_q[2].y);
    bbox_empty = (xmax_raw < CZERO) || (xmin_raw > XLIM) ||
                 (ymax_raw < CZERO) || (ymin_raw > YLIM);
    bbox_c.xmin = (xmin_raw < CZERO) ? CZERO : xmin_raw;
    bbox_c.xmax = (xmax_raw > XLIM)  ? XLIM  : xmax_raw;
    bbox_c.ymin = (ymin_raw < CZERO) ? CZERO : ymin_raw;
    bbox_c.ymax = (ymax_raw > YLIM)  ? YLIM  : ymax_raw;
  end
`else
  // Full-frame sweep: coverage alone decides which pixels are written.
  always_comb begin
    bbox_empty  = 1'b0;
    bbox_c.xmin = '0;
    bbox_c.xmax = XLIM;
    bbox_c.ymin = '0;
    bbox_c.ymax = YLIM;
  end
`endif

  // Main FSM: accept, set up bbox, sweep coords, drain the pipe, or clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      tri_q         <= '0;
      color_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      xmin_q        <= '0;
      xmax_q        <= '0;
      ymax_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_addr_q  <= '0;
      clr_we_q      <= 1'b0;
      clr_addr_q    <= '0;
      clear_pend_q  <= 1'b0;
      tri_done_q    <= 1'b0;
    end else begin
      tri_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clear_pend_q || clear_req) begin
            state_q      <= StClear;
            clear_pend_q <= 1'b0;
            clr_we_q     <= 1'b1;
            clr_addr_q   <= '0;
            tri_done_q   <= (LAST_ADDR == '0);
          end else if (tri_valid) begin
            state_q <= StSetup;
            tri_q   <= tri_in;
            color_q <= tri_color;
          end
        end
        StSetup: begin
          clear_pend_q <= clear_pend_q | clear_req;
          if (bbox_empty) begin
            state_q    <= StIdle;
            tri_done_q <= 1'b1;
          end else begin
            state_q       <= StSweep;
            xmin_q        <= bbox_c.xmin;
            xmax_q        <= bbox_c.xmax;
            ymax_q        <= bbox_c.ymax;
            x_q           <= bbox_c.xmin;
            y_q           <= bbox_c.ymin;
            issue_valid_q <= 1'b1;
            issue_addr_q  <= addr_of(bbox_c.xmin, bbox_c.ymin);
          end
        end
        StSweep: begin
          clear_pend_q <= clear_pend_q | clear_req;
          if (x_q == xmax_q) begin
            if (y_q == ymax_q) begin
              issue_valid_q <= 1'b0;
              state_q       <= StDrain;
            end else begin
              x_q          <= xmin_q;
              y_q          <= y_q + CONE;
              issue_addr_q <= addr_of(xmin_q, y_q + CONE);
            end
          end else begin
            x_q          <= x_q + CONE;
            issue_addr_q <= issue_addr_q + ADDR_BITS'(1);
          end
        end
        StDrain: begin
          clear_pend_q <= clear_pend_q | clear_req;
          if (!pipe_any) begin
            state_q    <= StIdle;
            tri_done_q <= 1'b1;
          end
        end
        StClear: begin
          clear_pend_q <= clear_pend_q | clear_req;
          if (clr_addr_q == LAST_ADDR) begin
            clr_we_q <= 1'b0;
            state_q  <= StIdle;
          end else begin
            clr_addr_q <= clr_addr_q + ADDR_BITS'(1);
            // Flag lands in the same cycle as the final clear write.
            tri_done_q <= (clr_addr_q + ADDR_BITS'(1) == LAST_ADDR);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  rsw_addr_pipe #(
    .DEPTH (FILL_LATENCY),
    .WIDTH (ADDR_BITS)
  ) u_addr_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_valid_q),
    .in_addr   (issue_addr_q),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr),
    .any_valid (pipe_any)
  );

  // Outputs: clear writes and coverage-gated sweep writes never overlap.
  always_comb begin
    tri_ready     = !rst && (state_q == StIdle) && !clear_pend_q && !clear_req;
    busy          = (state_q != StIdle) || issue_valid_q || pipe_any;
    tri_done      = tri_done_q;
    fill_hcount   = x_q;
    fill_vcount   = y_q;
    fill_triangle = tri_q;
    pix_we        = !rst && (clr_we_q || (pipe_valid && fill_is_within));
    pix_addr      = clr_we_q ? clr_addr_q : pipe_addr;
    pix_data      = clr_we_q ? CLEAR_COLOR : color_q;
  end

endmodule

// File: tb/tb_raster_sweep_writer.sv
// Scoreboard bench for raster_sweep_writer on an 8x6 frame with a 3-cycle
// edge-function coverage model standing in for the coverage unit.
module tb_raster_sweep_writer;
  import raster_sweep_writer_pkg::*;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int FL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tri_valid = 1'b0;
  logic        clear_req = 1'b0;
  tri_2d       tri_in = '0;
  logic [15:0] tri_color = '0;
  logic        tri_ready, busy, tri_done, fill_is_within, pix_we;
  logic [15:0] fill_hcount, fill_vcount, pix_data;
  tri_2d       fill_triangle;
  logic [17:0] pix_addr;

  raster_sweep_writer #(
    .FRAME_WIDTH  (W),
    .FRAME_HEIGHT (H),
    .FILL_LATENCY (FL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tri_valid      (tri_valid),
    .tri_ready      (tri_ready),
    .tri_in         (tri_in),
    .tri_color      (tri_color),
    .clear_req      (clear_req),
    .busy           (busy),
    .tri_done       (tri_done),
    .fill_hcount    (fill_hcount),
    .fill_vcount    (fill_vcount),
    .fill_triangle  (fill_triangle),
    .fill_is_within (fill_is_within),
    .pix_we         (pix_we),
    .pix_addr       (pix_addr),
    .pix_data       (pix_data)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t sb[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  done_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit covered(input int px, input int py, input tri_2d t);
    int x0, y0, x1, y1, x2, y2, e0, e1, e2;
    x0 = int'($signed(t[0].x)); y0 = int'($signed(t[0].y));
    x1 = int'($signed(t[1].x)); y1 = int'($signed(t[1].y));
    x2 = int'($signed(t[2].x)); y2 = int'($signed(t[2].y));
    e0 = (x1 - x0) * (py - y0) - (y1 - y0) * (px - x0);
    e1 = (x2 - x1) * (py - y1) - (y2 - y1) * (px - x1);
    e2 = (x0 - x2) * (py - y2) - (y0 - y2) * (px - x2);
    return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
  endfunction

  function automatic tri_2d mk_tri(input int ax, input int ay, input int bx, input int by,
                                   input int cx, input int cy);
    tri_2d t;
    t[0].x = 16'(ax); t[0].y = 16'(ay);
    t[1].x = 16'(bx); t[1].y = 16'(by);
    t[2].x = 16'(cx); t[2].y = 16'(cy);
    return t;
  endfunction

  // Coverage unit model: answer for the coord shown FL cycles earlier.
  logic [2:0] cov_sr = '0;
  always @(posedge clk)
    cov_sr <= {cov_sr[1:0], covered(int'($signed(fill_hcount)), int'($signed(fill_vcount)),
                                    fill_triangle)};
  assign fill_is_within = cov_sr[2];

  // Write monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (tri_done) done_count++;
    if (pix_we) begin
      if (sb.size() == 0) begin
        check_eq("spurious_we", pix_we, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("wr_addr", pix_addr, mon_e.addr);
        check_eq("wr_data", pix_data, mon_e.data);
      end
    end
  end

  task automatic push_clear();
    for (int a = 0; a < W * H; a++) sb.push_back('{a, 0});
  endtask

  // Expected writes of one triangle in raster order; only the first max_n coords count.
  task automatic push_tri(input tri_2d t, input int col, input int max_n,
                          output int area, output bit empty, output int n_cov);
    int xmin, xmax, ymin, ymax, n;
`ifdef RAST_BBOX_EN
    int xs[3], ys[3];
    for (int i = 0; i < 3; i++) begin
      xs[i] = int'($signed(t[i].x));
      ys[i] = int'($signed(t[i].y));
    end
    xmin = xs[0]; xmax = xs[0]; ymin = ys[0]; ymax = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < xmin) xmin = xs[i];
      if (xs[i] > xmax) xmax = xs[i];
      if (ys[i] < ymin) ymin = ys[i];
      if (ys[i] > ymax) ymax = ys[i];
    end
    empty = (xmax < 0) || (xmin > W - 1) || (ymax < 0) || (ymin > H - 1);
    if (xmin < 0) xmin = 0;
    if (ymin < 0) ymin = 0;
    if (xmax > W - 1) xmax = W - 1;
    if (ymax > H - 1) ymax = H - 1;
`else
    xmin = 0; xmax = W - 1; ymin = 0; ymax = H - 1;
    empty = 1'b0;
`endif
    area  = empty ? 0 : (xmax - xmin + 1) * (ymax - ymin + 1);
    n     = 0;
    n_cov = 0;
    if (!empty) begin
      for (int y = ymin; y <= ymax; y++) begin
        for (int x = xmin; x <= xmax; x++) begin
          if (n < max_n && covered(x, y, t)) begin
            sb.push_back('{y * W + x, col});
            n_cov++;
          end
          n++;
        end
      end
    end
  endtask

  task automatic run_tri(input string tag, input tri_2d t, input logic [15:0] col,
                         input bit with_clear, input int clear_at);
    int   area, exp_done, done_k, d0, n_cov;
    bit   empty, accepted;
    logic rdy_at_done;
    if (with_clear) push_clear();
    push_tri(t, int'(col), 1 << 30, area, empty, n_cov);
    exp_done = empty ? 2 : 3 + area + FL;
    @(posedge clk); #1;
    tri_valid = 1'b1; tri_in = t; tri_color = col; clear_req = with_clear;
    accepted = 1'b0;
    for (int i = 0; i < 300 && !accepted; i++) begin
      @(negedge clk);
      accepted = tri_ready;
      @(posedge clk); #1;
      clear_req = 1'b0;
    end
    tri_valid = 1'b0;
    check_eq({tag, "_accept"}, accepted, 1'b1);
    if (!accepted) return;
    if (with_clear) check_eq({tag, "_clear_first"}, sb.size(), n_cov);
    d0 = done_count;
    done_k = 0;
    rdy_at_done = 1'b0;
    for (int k = 1; k <= 400 && done_k == 0; k++) begin
      if (k == clear_at) begin
        clear_req = 1'b1;
        push_clear();
      end
      @(negedge clk);
      if (tri_done) begin
        done_k = k;
        rdy_at_done = tri_ready;
      end
      @(posedge clk); #1;
      clear_req = 1'b0;
    end
    check_eq({tag, "_done_cycle"}, done_k, exp_done);
    check_eq({tag, "_done_once"}, done_count - d0, 1);
    check_eq({tag, "_ready_at_done"}, rdy_at_done, clear_at < 0);
  endtask

  task automatic run_clear();
    int          done_k;
    logic [17:0] last_addr;
    logic        last_we;
    push_clear();
    @(posedge clk); #1 clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    done_k = 0; last_addr = '0; last_we = 1'b0;
    for (int k = 1; k <= 200 && done_k == 0; k++) begin
      @(negedge clk);
      if (tri_done) begin
        done_k = k; last_addr = pix_addr; last_we = pix_we;
      end
    end
    check_eq("clr_done_cycle", done_k, W * H);
    check_eq("clr_last_addr", last_addr, W * H - 1);
    check_eq("clr_last_we", last_we, 1'b1);
    @(negedge clk);
    check_eq("clr_busy_after", busy, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    check_eq({tag, "_idle"}, busy, 1'b0);
    check_eq({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    tri_2d t1, t3, t4;
    int    area, n_cov;
    bit    empty;
    t1 = mk_tri(1, 1, 5, 1, 1, 4);
    t3 = mk_tri(-9, 0, -2, 0, -5, 3);
    t4 = mk_tri(-3, -3, 20, -3, -3, 20);

    // Reset state
    @(negedge clk);
    check_eq("rst_ready", tri_ready, 1'b0);
    check_eq("rst_we", pix_we, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", tri_ready, 1'b1);
    check_eq("post_rst_done", tri_done, 1'b0);
    check_eq("post_rst_addr", pix_addr, 0);
    check_eq("post_rst_data", pix_data, 0);
    check_eq("post_rst_hcount", fill_hcount, 0);

    run_tri("t1", t1, 16'h0F00, 1'b0, -1);
    wait_idle("t1");
    run_clear();
    wait_idle("t2");
    run_tri("t3", t3, 16'h00F0, 1'b0, -1);
    wait_idle("t3");
    run_tri("t4", t4, 16'h1234, 1'b0, -1);
    wait_idle("t4");
    run_tri("t5a", t1, 16'h0ABC, 1'b1, -1);
    wait_idle("t5a");
    run_tri("t5b", t1, 16'h0555, 1'b0, 10);
    wait_idle("t5b");

    // Reset five cycles into the sweep: only writes from cycles 5 and 6 survive.
    push_tri(t1, 16'h0777, 2, area, empty, n_cov);
    @(posedge clk); #1;
    tri_valid = 1'b1; tri_in = t1; tri_color = 16'h0777;
    @(negedge clk);
    check_eq("t6_ready", tri_ready, 1'b1);
    @(posedge clk); #1 tri_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_ready", tri_ready, 1'b0);
    check_eq("t6_rst_we", pix_we, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_ready_after", tri_ready, 1'b1);
    check_eq("t6_we_after", pix_we, 1'b0);
    repeat (8) @(negedge clk);
    check_eq("t6_sb_drained", sb.size(), 0);

    run_tri("t7", t4, 16'h4321, 1'b0, -1);
    wait_idle("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
